// File: rtl/sramx_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sramx_responder
//  Purpose  : Memory-side responder for the SRAM-like bus. Byte-lane writes,
//             fixed-latency reads, out-of-range detection with error counter.
//  Revision : 1.0 - initial release
// ============================================================================
module sramx_responder #(
    parameter int          DEPTH_LOG2 = 14,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             sram_en,
    input  logic [3:0]       sram_wen,
    input  logic [31:0]      sram_addr,
    input  logic [31:0]      sram_wdata,
    output logic [31:0]      sram_rdata,
    output logic             rvalid,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int               c_DEPTH   = 1 << DEPTH_LOG2;
    // One bit wider than the address so large depths cannot overflow the span.
    localparam logic [32:0]      c_SPAN    = 33'd4 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]           r_mem [0:c_DEPTH-1];
    logic [31:0]           r_rdata;
    logic                  r_rvalid;
    logic [CNT_W-1:0]      r_err_cnt;

    logic [31:0]           w_off;
    logic                  w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_wr_req;
    logic                  w_rd_req;
    logic [31:0]           w_rd_dat;
    logic                  w_last_vld;
    logic [31:0]           w_last_dat;

    // Addresses below the base wrap to huge offsets and fall out of range.
    assign w_off      = sram_addr - BASE_ADDR;
    assign w_in_range = ({1'b0, w_off} < c_SPAN);
    assign w_idx      = w_off[DEPTH_LOG2+1:2];
    assign w_wr_req   = sram_en && w_in_range && (sram_wen != 4'h0);
    assign w_rd_req   = sram_en && (sram_wen == 4'h0);
    assign w_rd_dat   = w_in_range ? r_mem[w_idx] : ERR_DATA;

    // Array has no reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (resetn && w_wr_req) begin
            for (int l = 0; l < 4; l++) begin
                if (sram_wen[l]) begin
                    r_mem[w_idx][8*l +: 8] <= sram_wdata[8*l +: 8];
                end
            end
        end
    end

    generate
        if (LATENCY <= 1) begin : g_lat_direct
            assign w_last_vld = w_rd_req;
            assign w_last_dat = w_rd_dat;
        end else begin : g_lat_pipe
            logic        r_vld [0:LATENCY-2];
            logic [31:0] r_dat [0:LATENCY-2];

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        r_vld[i] <= 1'b0;
                        r_dat[i] <= 32'h0;
                    end
                end else begin
                    r_vld[0] <= w_rd_req;
                    r_dat[0] <= w_rd_dat;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_dat[i] <= r_dat[i-1];
                    end
                end
            end

            assign w_last_vld = r_vld[LATENCY-2];
            assign w_last_dat = r_dat[LATENCY-2];
        end
    endgenerate

    // Final stage: rdata only moves on a completed read, otherwise holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata  <= 32'h0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_last_vld;
            if (w_last_vld) begin
                r_rdata <= w_last_dat;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err_cnt <= '0;
        end else if (sram_en && !w_in_range && (r_err_cnt != c_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign sram_rdata = r_rdata;
    assign rvalid     = r_rvalid;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sramx_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sramx_responder
//  Purpose  : Directed and randomized checks of sramx_responder across
//             latency 1/2/3 instances against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sramx_responder;

    localparam logic [31:0] c_B1  = 32'h0000_1000;
    localparam logic [31:0] c_B2  = 32'h0000_0100;
    localparam logic [31:0] c_B3  = 32'h8000_0000;
    localparam logic [31:0] c_ERR = 32'hDEAD_BEEF;

    typedef struct {
        int          due;
        logic [31:0] d;
    } resp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en1, en2, en3;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;

    logic [31:0] rd1, rd2, rd3;
    logic        rv1, rv2, rv3;
    logic [15:0] err1;
    logic [1:0]  err2;
    logic [7:0]  err3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sramx_responder #(.DEPTH_LOG2(6), .BASE_ADDR(c_B1), .LATENCY(1), .ERR_DATA(c_ERR), .CNT_W(16)) u1 (
        .clk(clk), .resetn(resetn), .sram_en(en1), .sram_wen(wen), .sram_addr(addr),
        .sram_wdata(wdata), .sram_rdata(rd1), .rvalid(rv1), .err_cnt(err1));

    sramx_responder #(.DEPTH_LOG2(4), .BASE_ADDR(c_B2), .LATENCY(2), .ERR_DATA(c_ERR), .CNT_W(2)) u2 (
        .clk(clk), .resetn(resetn), .sram_en(en2), .sram_wen(wen), .sram_addr(addr),
        .sram_wdata(wdata), .sram_rdata(rd2), .rvalid(rv2), .err_cnt(err2));

    sramx_responder #(.DEPTH_LOG2(4), .BASE_ADDR(c_B3), .LATENCY(3), .ERR_DATA(c_ERR), .CNT_W(8)) u3 (
        .clk(clk), .resetn(resetn), .sram_en(en3), .sram_wen(wen), .sram_addr(addr),
        .sram_wdata(wdata), .sram_rdata(rd3), .rvalid(rv3), .err_cnt(err3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] m3 [0:15];
    resp_t       q3 [$];
    logic [31:0] exp_rd3;
    int          err_m3;
    int          off;
    logic [31:0] exp_v3 [0:5];
    logic [31:0] exp_d3 [0:5];

    initial begin
        resetn = 1'b0;
        en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
        wen = 4'hF; addr = c_B1 + 32'h10; wdata = 32'hFFFF_FFFF;
        u1.r_mem[4]  = 32'h0BAD_F00D;
        u1.r_mem[0]  = 32'hCAFE_0000;
        u1.r_mem[63] = 32'h600D_CAFE;
        u2.r_mem[1]  = 32'h0000_0077;
        for (int i = 0; i < 16; i++) begin
            m3[i] = (i < 3) ? 32'(i + 1) : $urandom;
            u3.r_mem[i] = m3[i];
        end

        // Reset held with a live write request
        repeat (3) @(negedge clk);
        chk("rst_rdata",   rd1, 32'h0);
        chk("rst_rvalid",  {31'b0, rv1}, 32'h0);
        chk("rst_err",     {16'b0, err1}, 32'h0);
        chk("rst_nowrite", u1.r_mem[4], 32'h0BAD_F00D);
        chk("rst_rvalid3", {31'b0, rv3}, 32'h0);
        chk("rst_err3",    {24'b0, err3}, 32'h0);
        en1 = 1'b0; en2 = 1'b0; en3 = 1'b0; wen = 4'h0; resetn = 1'b1;
        @(negedge clk);

        // Byte lanes
        en1 = 1'b1; wen = 4'hF; addr = c_B1 + 32'h10; wdata = 32'h1122_3344;
        @(negedge clk);
        wen = 4'b0010; addr = c_B1 + 32'h12; wdata = 32'hAABB_CCDD;
        @(negedge clk);
        chk("wr_no_rvalid", {31'b0, rv1}, 32'h0);
        wen = 4'h0; addr = c_B1 + 32'h10;
        @(negedge clk);
        chk("lane_rvalid", {31'b0, rv1}, 32'h1);
        chk("lane_rdata",  rd1, 32'h1122_CC44);
        en1 = 1'b0;
        @(negedge clk);
        chk("idle_rvalid", {31'b0, rv1}, 32'h0);
        chk("idle_hold",   rd1, 32'h1122_CC44);

        // Idle request ignored, then read-after-write
        wen = 4'hF; wdata = 32'hFFFF_FFFF; addr = c_B1 + 32'h10;
        @(negedge clk);
        en1 = 1'b1; wen = 4'h0;
        @(negedge clk);
        chk("idle_nowrite", rd1, 32'h1122_CC44);
        wen = 4'hF; addr = c_B1 + 32'h20; wdata = 32'h0000_0055;
        @(negedge clk);
        wen = 4'h0;
        @(negedge clk);
        chk("raw_rvalid", {31'b0, rv1}, 32'h1);
        chk("raw_rdata",  rd1, 32'h0000_0055);

        // Range boundaries
        addr = c_B1 + 32'h100;
        @(negedge clk);
        chk("oor_rdata", rd1, c_ERR);
        chk("oor_err1",  {16'b0, err1}, 32'd1);
        wen = 4'hF; wdata = 32'h1234_5678;
        @(negedge clk);
        chk("oor_wr_rvalid", {31'b0, rv1}, 32'h0);
        chk("oor_err2",      {16'b0, err1}, 32'd2);
        chk("oor_wr_drop",   u1.r_mem[0], 32'hCAFE_0000);
        wen = 4'h0; addr = c_B1 - 32'd4;
        @(negedge clk);
        chk("below_rdata", rd1, c_ERR);
        chk("below_err3",  {16'b0, err1}, 32'd3);
        addr = c_B1 + 32'hFC;
        @(negedge clk);
        chk("top_rdata", rd1, 32'h600D_CAFE);
        chk("top_err",   {16'b0, err1}, 32'd3);
        en1 = 1'b0;

        // Counter saturation on a 2-bit counter
        en2 = 1'b1; addr = c_B2 + 32'h40;
        for (int i = 0; i < 5; i++) begin
            wen = (i % 2 == 0) ? 4'h0 : 4'h3;
            @(negedge clk);
        end
        en2 = 1'b0; wen = 4'h0;
        @(negedge clk);
        chk("sat_err", {30'b0, err2}, 32'd3);

        // Latency-3 pipeline, back-to-back reads
        exp_v3 = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd0};
        exp_d3 = '{32'd0, 32'd0, 32'd1, 32'd2, 32'd3, 32'd3};
        en3 = 1'b1; wen = 4'h0;
        for (int k = 0; k < 6; k++) begin
            addr = c_B3 + 32'(4 * k);
            en3  = (k < 3);
            @(negedge clk);
            chk($sformatf("pipe_rvalid%0d", k), {31'b0, rv3}, exp_v3[k]);
            if (exp_v3[k] == 32'd1) chk($sformatf("pipe_rdata%0d", k), rd3, exp_d3[k]);
        end
        en3 = 1'b0;

        // Randomized traffic against the reference model
        exp_rd3 = 32'd3;
        err_m3  = 0;
        for (int n = 0; n < 300; n++) begin
            logic ev;
            ev = 1'b0;
            if (q3.size() > 0 && q3[0].due == cyc) begin
                ev = 1'b1;
                exp_rd3 = q3[0].d;
                void'(q3.pop_front());
            end
            chk("rnd_rvalid", {31'b0, rv3}, {31'b0, ev});
            chk("rnd_rdata",  rd3, exp_rd3);
            chk("rnd_err",    {24'b0, err3}, 32'(err_m3));

            en3   = (n < 296) && ($urandom_range(0, 3) != 0);
            wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            off   = int'($urandom_range(0, 21)) * 4 - 12 + int'($urandom_range(0, 3));
            addr  = c_B3 + 32'(off);
            wdata = $urandom;
            if (en3) begin
                if (off >= 0 && off < 64) begin
                    if (wen == 4'h0) begin
                        q3.push_back('{cyc + 3, m3[off / 4]});
                    end else begin
                        for (int l = 0; l < 4; l++)
                            if (wen[l]) m3[off / 4][8*l +: 8] = wdata[8*l +: 8];
                    end
                end else begin
                    if (err_m3 < 255) err_m3++;
                    if (wen == 4'h0) q3.push_back('{cyc + 3, c_ERR});
                end
            end
            @(negedge clk);
        end
        chk("rnd_drained", 32'(q3.size()), 32'd0);
        en3 = 1'b0;

        // Reset while a latency-2 read is in flight
        en2 = 1'b1; wen = 4'h0; addr = c_B2 + 32'h4;
        @(negedge clk);
        en2 = 1'b0; resetn = 1'b0;
        chk("mid_rvalid_a", {31'b0, rv2}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mid_rvalid", {31'b0, rv2}, 32'h0);
        end
        chk("mid_rdata", rd2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
